// File: rtl/fifo_pkg.sv
// Shared helpers for the dual-clock FIFO: width-independent Gray/binary
// conversion and the default pointer type.
package fifo_pkg;

  localparam int unsigned FIFO_DEPTH = 16;
  localparam int unsigned FIFO_AW    = $clog2(FIFO_DEPTH);

  typedef logic [FIFO_AW:0] ptr_t;

  // Operands are zero-extended to 32 bits, so one body serves every pointer width.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = 32'd0;
    for (int i = 0; i < 32; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// Read-side bus of the dual-clock FIFO. The uf_clr/underflow pair exists only
// when FIFO_RD_UNDERFLOW_EN is defined.
interface fifo_rd_ctrl_if #(
  parameter int unsigned AW = 4
);

  logic          rd_rq;
  logic [AW:0]   rsync_ptr2;
  logic [AW-1:0] raddr;
  logic [AW:0]   rptr;
  logic          empty;
  logic          aempty;
  logic [AW:0]   rlevel;
`ifdef FIFO_RD_UNDERFLOW_EN
  logic          uf_clr;
  logic          underflow;

  modport master (
    output rd_rq, rsync_ptr2, uf_clr,
    input  raddr, rptr, empty, aempty, rlevel, underflow
  );

  modport slave (
    input  rd_rq, rsync_ptr2, uf_clr,
    output raddr, rptr, empty, aempty, rlevel, underflow
  );
`else
  modport master (
    output rd_rq, rsync_ptr2,
    input  raddr, rptr, empty, aempty, rlevel
  );

  modport slave (
    input  rd_rq, rsync_ptr2,
    output raddr, rptr, empty, aempty, rlevel
  );
`endif

endinterface

// File: rtl/fifo_gray2bin.sv
// Combinational Gray-to-binary converter, shared by the read and write sides.
module fifo_gray2bin
  import fifo_pkg::*;
#(
  parameter int unsigned W = 5
) (
  input  logic [W-1:0] gray_i,
  output logic [W-1:0] bin_o
);

  // XOR-prefix from the MSB down.
  always_comb begin
    bin_o = W'(gray2bin(32'(gray_i)));
  end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side control of the dual-clock FIFO: read pointers, empty, fill level,
// almost-empty, and a sticky underflow flag when FIFO_RD_UNDERFLOW_EN is defined.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AE_THRESH = 2
) (
  input  logic          r_clk,
  input  logic          rst,
  fifo_rd_ctrl_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [PW-1:0] AE_LVL = PW'(AE_THRESH);

  if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("fifo_rd_ctrl: DEPTH must be a power of two and at least 4");
  end
  if (AE_THRESH >= DEPTH) begin : g_bad_thresh
    $error("fifo_rd_ctrl: AE_THRESH must be below DEPTH");
  end

  logic [PW-1:0] bin_q, bin_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] rlevel_q, rlevel_d;
  logic [PW-1:0] wbin_s;
  logic          empty_q, empty_d;
  logic          aempty_q, aempty_d;
  logic          rd_acc_s;

  fifo_gray2bin #(.W(PW)) u_wptr_g2b (
    .gray_i (bus.rsync_ptr2),
    .bin_o  (wbin_s)
  );

  // Flags compare against the new read pointer so a simultaneous last read and write keep empty low.
  always_comb begin
    rd_acc_s = bus.rd_rq & ~empty_q;
    bin_d    = bin_q + {{AW{1'b0}}, rd_acc_s};
    rptr_d   = PW'(bin2gray(32'(bin_d)));
    empty_d  = (rptr_d == bus.rsync_ptr2);
    rlevel_d = wbin_s - bin_d;
    aempty_d = (rlevel_d <= AE_LVL);
  end

  always_ff @(posedge r_clk) begin
    if (rst) begin
      bin_q    <= {PW{1'b0}};
      rptr_q   <= {PW{1'b0}};
      rlevel_q <= {PW{1'b0}};
      empty_q  <= 1'b1;
      aempty_q <= 1'b1;
    end else begin
      bin_q    <= bin_d;
      rptr_q   <= rptr_d;
      rlevel_q <= rlevel_d;
      empty_q  <= empty_d;
      aempty_q <= aempty_d;
    end
  end

  assign bus.raddr  = bin_q[AW-1:0];
  assign bus.rptr   = rptr_q;
  assign bus.empty  = empty_q;
  assign bus.aempty = aempty_q;
  assign bus.rlevel = rlevel_q;

`ifdef FIFO_RD_UNDERFLOW_EN
  logic uf_q, uf_d;

  // Set wins over a simultaneous clear.
  always_comb begin
    uf_d = (uf_q & ~bus.uf_clr) | (bus.rd_rq & empty_q);
  end

  always_ff @(posedge r_clk) begin
    if (rst) begin
      uf_q <= 1'b0;
    end else begin
      uf_q <= uf_d;
    end
  end

  assign bus.underflow = uf_q;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl (DEPTH=16, AE_THRESH=2) with a counter-based model.
module tb_fifo_rd_ctrl;
  import fifo_pkg::*;

  logic clk;
  logic rst;
  logic uf_clr_s;
  int   n_vec;
  int   n_err;

  // Model state: read count and derived level, all plain integers modulo 32.
  int m_rd;
  int m_level;
  bit m_empty;
  bit m_aempty;
  bit m_uf;

  fifo_rd_ctrl_if #(.AW(4)) bus ();

  fifo_rd_ctrl #(.DEPTH(16), .AE_THRESH(2)) dut (
    .r_clk (clk),
    .rst   (rst),
    .bus   (bus)
  );

`ifdef FIFO_RD_UNDERFLOW_EN
  assign bus.uf_clr = uf_clr_s;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int gray_of(input int v);
    return (v ^ (v >> 1)) & 31;
  endfunction

  // Decode by search so the model does not share the RTL's XOR-prefix.
  function automatic int gray_decode(input int g);
    for (int w = 0; w < 32; w++) begin
      if (gray_of(w) == g) return w;
    end
    return -1;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: advance the model on the edge, then compare every output.
  task automatic step();
    int w;
    int acc;
    @(posedge clk);
    if (rst) begin
      m_rd = 0; m_level = 0; m_empty = 1'b1; m_aempty = 1'b1; m_uf = 1'b0;
    end else begin
      w     = gray_decode(int'(bus.rsync_ptr2));
      acc   = (bus.rd_rq && !m_empty) ? 1 : 0;
      m_uf  = (m_uf && !uf_clr_s) || (bus.rd_rq && m_empty);
      m_rd  = (m_rd + acc) % 32;
      m_level  = (w - m_rd + 32) % 32;
      m_empty  = (m_level == 0);
      m_aempty = (m_level <= 2);
    end
    #1;
    chk("rptr",   int'(bus.rptr),   gray_of(m_rd));
    chk("raddr",  int'(bus.raddr),  m_rd % 16);
    chk("empty",  int'(bus.empty),  int'(m_empty));
    chk("aempty", int'(bus.aempty), int'(m_aempty));
    chk("rlevel", int'(bus.rlevel), m_level);
`ifdef FIFO_RD_UNDERFLOW_EN
    chk("underflow", int'(bus.underflow), int'(m_uf));
`endif
  endtask

  initial begin
    ptr_t wp;
    n_vec = 0; n_err = 0;
    m_rd = 0; m_level = 0; m_empty = 1'b1; m_aempty = 1'b1; m_uf = 1'b0;
    rst = 1'b1; uf_clr_s = 1'b0;
    wp = 5'b00000;
    bus.rd_rq = 1'b1;
    bus.rsync_ptr2 = wp;

    // Reset held two cycles with a pending request
    step(); step();
    chk("rst_rptr",   int'(bus.rptr),   0);
    chk("rst_raddr",  int'(bus.raddr),  0);
    chk("rst_empty",  int'(bus.empty),  1);
    chk("rst_aempty", int'(bus.aempty), 1);
    chk("rst_rlevel", int'(bus.rlevel), 0);
`ifdef FIFO_RD_UNDERFLOW_EN
    chk("rst_uf", int'(bus.underflow), 0);
`endif

    // Three entries written
    rst = 1'b0; bus.rd_rq = 1'b0; bus.rsync_ptr2 = 5'b00010;
    step();
    chk("fill_empty",  int'(bus.empty),  0);
    chk("fill_rlevel", int'(bus.rlevel), 3);
    chk("fill_aempty", int'(bus.aempty), 0);

    bus.rd_rq = 1'b1;
    step();
    chk("rd1_raddr",  int'(bus.raddr),  1);
    chk("rd1_rptr",   int'(bus.rptr),   1);
    chk("rd1_rlevel", int'(bus.rlevel), 2);
    chk("rd1_aempty", int'(bus.aempty), 1);

    step(); step();
    chk("drain_empty", int'(bus.empty), 1);
    chk("drain_rptr",  int'(bus.rptr),  2);
    chk("drain_raddr", int'(bus.raddr), 3);

    step();
    chk("uf_raddr_hold", int'(bus.raddr), 3);
`ifdef FIFO_RD_UNDERFLOW_EN
    chk("uf_set", int'(bus.underflow), 1);
`endif
    bus.rd_rq = 1'b0; uf_clr_s = 1'b1;
    step();
`ifdef FIFO_RD_UNDERFLOW_EN
    chk("uf_clr", int'(bus.underflow), 0);
`endif
    bus.rd_rq = 1'b1;
    step();
`ifdef FIFO_RD_UNDERFLOW_EN
    chk("uf_set_wins", int'(bus.underflow), 1);
`endif
    uf_clr_s = 1'b0; bus.rd_rq = 1'b0;

    // Wrap: restart from bin=0 with a full FIFO, then drain all sixteen
    rst = 1'b1; bus.rsync_ptr2 = 5'b11000;
    step();
    rst = 1'b0;
    step();
    chk("wrap_full_level", int'(bus.rlevel), 16);
    bus.rd_rq = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      chk("wrap_raddr",  int'(bus.raddr),  (i + 1) % 16);
      chk("wrap_rlevel", int'(bus.rlevel), 15 - i);
    end
    chk("wrap_rptr",  int'(bus.rptr),  24);
    chk("wrap_empty", int'(bus.empty), 1);
    bus.rd_rq = 1'b0;

    // Last read coincides with a write
    bus.rsync_ptr2 = 5'b11001;
    step();
    chk("sim_pre_level", int'(bus.rlevel), 1);
    bus.rd_rq = 1'b1; bus.rsync_ptr2 = 5'b11011;
    step();
    chk("sim_empty",  int'(bus.empty),  0);
    chk("sim_rlevel", int'(bus.rlevel), 1);
    chk("sim_raddr",  int'(bus.raddr),  1);

    // Reset with five entries pending
    bus.rd_rq = 1'b0; bus.rsync_ptr2 = 5'b11101;
    step();
    chk("mid_pre_level", int'(bus.rlevel), 5);
    rst = 1'b1; bus.rd_rq = 1'b1;
    step();
    chk("mid_rptr",   int'(bus.rptr),   0);
    chk("mid_empty",  int'(bus.empty),  1);
    chk("mid_rlevel", int'(bus.rlevel), 0);
    rst = 1'b0; bus.rd_rq = 1'b0; bus.rsync_ptr2 = 5'b00011;
    step();
    chk("post_empty",  int'(bus.empty),  0);
    chk("post_rlevel", int'(bus.rlevel), 2);
    bus.rsync_ptr2 = 5'b00000;
    step();
    chk("post_empty2", int'(bus.empty), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
